// File: rtl/cnn_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cnn_mem_pkg : shared types/constants for rfdp read-port masters   |
// | Revision    : 1.0                                                 |
// +------------------------------------------------------------------+
package cnn_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int RD_LAT     = 1;
  localparam int SKID_DEPTH = 3;
  localparam int SKID_PW    = 2;

  // Pointer increment modulo the (non power-of-two) skid depth.
  function automatic logic [SKID_PW-1:0] skid_ptr_inc(input logic [SKID_PW-1:0] p);
    return (p == SKID_PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_skid_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rd_skid_fifo : 3-entry register FIFO, push and pop in one cycle   |
// | Revision     : 1.0                                                |
// +------------------------------------------------------------------+
module rd_skid_fifo
  import cnn_mem_pkg::*;
#(
  parameter int DW = 97
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0]      r_mem [SKID_DEPTH];
  logic [SKID_PW-1:0] r_wr_ptr;
  logic [SKID_PW-1:0] r_rd_ptr;
  logic [SKID_PW-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == SKID_PW'(SKID_DEPTH));
  assign w_pop    = pop && !empty;
  assign w_push   = push && (!full || w_pop);
  assign pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= skid_ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= skid_ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
`endif

endmodule
`default_nettype wire

// File: rtl/sram_burst_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sram_burst_reader : burst read master for rfdp macros, with a     |
// |                     credit-limited skid FIFO on the output stream |
// | Revision          : 1.0                                           |
// +------------------------------------------------------------------+
module sram_burst_reader
  import cnn_mem_pkg::*;
#(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 96,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [AW-1:0]    cmd_len,
  output logic             sram_cena,
  output logic [AW-1:0]    sram_aa,
  input  logic [WIDTH-1:0] sram_qa,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  rd_state_t        r_state;
  rd_state_t        w_state_nxt;
  logic [AW-1:0]    r_rd_addr;
  logic [AW-1:0]    r_rd_left;
  logic [1:0]       r_credit;
  logic             r_inflight;
  logic             r_inflight_last;
  logic             w_issue;
  logic             w_pop;
  logic             w_accept;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic [WIDTH:0]   w_head;

  // Credit covers FIFO occupancy plus the word in flight, so it never overflows.
  assign w_issue   = (r_state == RUN) && (r_credit < 2'(SKID_DEPTH));
  assign w_pop     = out_valid && out_ready;
  assign w_accept  = cmd_valid && cmd_ready;
  assign sram_cena = !w_issue;
  assign sram_aa   = r_rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        cmd_ready = !rst;
        busy      = 1'b0;
        if (cmd_valid && !rst) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_issue && (r_rd_left == '0)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_pop && out_last) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_rd_left <= '0;
    end else if (w_accept) begin
      r_rd_addr <= cmd_addr;
      r_rd_left <= cmd_len;
    end else if (w_issue) begin
      r_rd_addr <= r_rd_addr + 1'b1;
      r_rd_left <= r_rd_left - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_credit        <= '0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_rd_left == '0);
      case ({w_issue, w_pop})
        2'b10:   r_credit <= r_credit + 1'b1;
        2'b01:   r_credit <= r_credit - 1'b1;
        default: r_credit <= r_credit;
      endcase
    end
  end

  rd_skid_fifo #(
    .DW (WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_data ({r_inflight_last, sram_qa}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

  assign out_valid = !w_fifo_empty;
  assign out_data  = w_head[WIDTH-1:0];
  assign out_last  = out_valid && w_head[WIDTH];

`ifndef SYNTHESIS
  a_full_credit: assert property (@(posedge clk) disable iff (rst) w_fifo_full |-> (r_credit == 2'd3));
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_reader.sv
`default_nettype none
// Bench for sram_burst_reader: behavioural rfdp macro plus a queue-based
// reference of addresses, beats and availability times.
module tb_sram_burst_reader;

  localparam int DEPTH = 1024;
  localparam int WIDTH = 96;
  localparam int AW    = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_addr;
  logic [AW-1:0]    cmd_len;
  logic             sram_cena;
  logic [AW-1:0]    sram_aa;
  logic [WIDTH-1:0] sram_qa;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;

  always #5 clk = ~clk;

  sram_burst_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .sram_cena(sram_cena), .sram_aa(sram_aa), .sram_qa(sram_qa),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  // rfdp macro: one-cycle read latency; garbage on QA when not read.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) sram_qa <= sram_cena ? {$urandom, $urandom, $urandom} : mem[sram_aa];

  int n_assert = 0;
  int n_fail   = 0;

  bit             active;
  logic [AW-1:0]  q_addr [$];
  logic [WIDTH:0] q_data [$];
  int             q_avail [$];
  int             issued, popped, cyc, hs_cnt, done_cnt, hs_cyc;

  task automatic check(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    active = 1'b0;
    q_addr.delete();
    q_data.delete();
    q_avail.delete();
    issued = 0;
    popped = 0;
  endtask

  // One clock cycle: inputs were set by the caller; outputs checked at the negedge.
  task automatic tick();
    bit             act0;
    bit             exp_low;
    bit             exp_valid;
    logic [WIDTH:0] beat;
    logic [AW-1:0]  a;
    @(negedge clk);
    act0 = active;
    check("cmd_ready", cmd_ready, !active);
    check("busy", busy, active);
    exp_low = active && (q_addr.size() > 0) && ((issued - popped) < 3);
    check("sram_cena", sram_cena, !exp_low);
    if (!sram_cena && exp_low) begin
      check("sram_aa", sram_aa, q_addr.pop_front());
      issued++;
      q_avail.push_back(cyc + 2);
    end
    exp_valid = (q_avail.size() > 0) && (q_avail[0] <= cyc);
    check("out_valid", out_valid, exp_valid);
    if (out_valid && out_ready && exp_valid) begin
      beat = q_data.pop_front();
      check("beat", {out_last, out_data}, beat);
      void'(q_avail.pop_front());
      popped++;
      if (beat[WIDTH]) begin
        active = 1'b0;
        done_cnt++;
      end
    end
    if (cmd_valid && cmd_ready && !act0) begin
      for (int i = 0; i <= int'(cmd_len); i++) begin
        a = AW'(int'(cmd_addr) + i);
        q_addr.push_back(a);
        q_data.push_back({(i == int'(cmd_len)), mem[a]});
      end
      active = 1'b1;
      hs_cnt++;
      hs_cyc = cyc;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high; 1: ready low in cycles 5..12; 2: random ready.
  // nb bursts are accepted with cmd_valid held until the last acceptance.
  task automatic run_burst(input int addr, input int len, input int mode, input int nb, input int stop_c);
    int start_done = done_cnt;
    int start_hs   = hs_cnt;
    int guard      = 0;
    int c;
    cmd_addr  = AW'(addr);
    cmd_len   = AW'(len);
    cmd_valid = 1'b1;
    while ((done_cnt - start_done) < nb && guard < 3000) begin
      c = (hs_cnt > start_hs) ? (cyc - hs_cyc) : -1;
      if (stop_c >= 0 && c == stop_c) break;
      case (mode)
        1:       out_ready = !(c >= 5 && c <= 12);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      tick();
      if ((hs_cnt - start_hs) >= nb) cmd_valid = 1'b0;
      guard++;
    end
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    if (stop_c < 0) check("bursts_done", (WIDTH+1)'(done_cnt - start_done), (WIDTH+1)'(nb));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
    cyc = 0; hs_cnt = 0; done_cnt = 0; hs_cyc = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_sram_cena", sram_cena, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;

    run_burst(10, 3, 0, 1, -1);
    run_burst(1022, 3, 0, 1, -1);
    run_burst(int'($urandom_range(0, DEPTH-1)), 0, 0, 1, -1);
    run_burst(int'($urandom_range(0, DEPTH-1)), 15, 1, 1, -1);
    run_burst(int'($urandom_range(0, DEPTH-1)), 255, 0, 2, -1);
    for (int k = 0; k < 6; k++)
      run_burst(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, 40)), 2, 1, -1);

    // Reset mid-burst: asynchronous assertion inside cycle 8 of a 32-word burst.
    run_burst(100, 31, 0, 1, 8);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_sram_cena", sram_cena, 1'b1);
    check("arst_cmd_ready", cmd_ready, 1'b0);
    check("arst_out_last", out_last, 1'b0);
    check("arst_busy", busy, 1'b0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) tick();
    run_burst(0, 1, 0, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_burst_reader.md
# sram_burst_reader

Read-port master for the 1-write/1-read register-file macros (`rfdpDEPTHxWIDTH` family). It accepts a burst command (start address, length), drives the macro's read port (active-low chip enable, 1-cycle read latency), and delivers the words in order on a valid/ready stream. Sits between an rfdp buffer, such as a feature-map or weight line buffer, and a downstream consumer, such as a PE array feeder, which may apply backpressure.

## Interface
- `DEPTH`, default 1024: words in the attached macro; power of two.
- `WIDTH`, default 96: word width in bits.
- `AW`, default $clog2(DEPTH): address width (derived; not overridden).
- `clk`  in  1  single clock for all logic; the macro's CLKA is tied to the same clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  burst command valid.
- `cmd_ready`  out  1  command accepted on cycle with cmd_valid&cmd_ready.
- `cmd_addr`  in  AW  first word address.
- `cmd_len`  in  AW  burst length minus one (0 → 1 word, DEPTH-1 → DEPTH words).
- `sram_cena`  out  1  macro CENA, active-low read enable.
- `sram_aa`  out  AW  macro AA.
- `sram_qa`  in  WIDTH  macro QA, valid the cycle after sram_cena low.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  consumer ready.
- `out_data`  out  WIDTH  read word.
- `out_last`  out  1  final word of burst, qualified by out_valid.
- `busy`  out  1  high from command accept until the last beat is transferred.

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On handshake, latch addr/len into rd_addr/rd_left and go to RUN.
  - RUN: issue reads; after the read with rd_left==0 is issued, go to DRAIN.
  - DRAIN: issue nothing; go to IDLE on the out_last handshake.
- Read issue rule:
  - sram_cena=0 iff state==RUN and credit<3.
  - credit = skid FIFO occupancy + reads in flight; range 0..3.
  - credit_next = credit + issue − pop, where pop = out_valid&out_ready.
  - Issue does not depend combinationally on out_ready.
- sram_aa = rd_addr. Each issue: rd_addr += 1 modulo DEPTH (natural AW-bit wrap), rd_left −= 1.
- Capture: a 1-bit `inflight` register, set on issue, marks sram_qa valid next cycle; that word is pushed into the 3-entry FIFO together with its last flag (last flag = issued with rd_left==0).
- The FIFO can never overflow by construction; an overflow is an assertion failure.
- Output: out_valid = FIFO non-empty; out_data/out_last come from the FIFO head.
- cmd_valid outside IDLE: ignored, cmd_ready=0; cmd_* are not sampled.
- Reset (any time, including mid-burst):
  - Outputs: cmd_ready=0 during reset and 1 from the first cycle after; sram_cena=1; out_valid=0; out_last=0; busy=0.
  - Internal: state=IDLE; credit, inflight and FIFO cleared; out_data don't-care.
  - The in-flight burst is discarded.

## Timing
- Command handshake in cycle 0 → sram_cena low in cycle 1 → sram_qa valid in cycle 2, pushed at the end of cycle 2 → out_valid in cycle 3 (latency 3).
- With out_ready held high: one word per cycle sustained; an N-word burst occupies out_valid for N consecutive cycles.
- Backpressure: at most 3 reads issued beyond the last popped word; reads resume the cycle after the first pop.
- Next command is accepted in the cycle after the out_last handshake (IDLE).
- busy falls in that same cycle.

## Structure
- Shared package `cnn_mem_pkg`: state enum `rd_state_t` {IDLE, RUN, DRAIN}; localparam `RD_LAT=1`; localparam `SKID_DEPTH=3`.
- One sub-module: `rd_skid_fifo`, a 3-entry register FIFO with {WIDTH+1}-bit entries, push/pop/empty/full, and pop and push allowed in the same cycle.
- The top level holds the FSM, address/length counters, credit counter and the inflight flag.

## Test plan
- Basic burst:
  - Stimulus: DEPTH=1024, behavioural rfdp1024x96 preloaded mem[i]=i; cmd addr=10, len=3, out_ready=1.
  - Response: out_data 10,11,12,13 on cycles 3–6; out_last only on 13; busy low and cmd_ready high in cycle 7.
- Wrap-around:
  - Stimulus: addr=1022, len=3.
  - Response: sram_aa 1022,1023,0,1; data in that order.
- Single word:
  - Stimulus: len=0.
  - Response: exactly one beat, with out_last=1 on it.
- Backpressure:
  - Stimulus: len=15; out_ready low in cycles 5–12.
  - Response: no more than 3 words issued beyond the last popped; sequence intact with no drops or duplicates; sram_cena held high while credit==3.
- Full throughput and rejection:
  - Stimulus: len=255, ready high; cmd_valid held high throughout.
  - Response: 256 beats in 256 consecutive cycles; cmd_ready low until the cycle after out_last; a second command is accepted only then.
- Reset mid-burst:
  - Stimulus: assert rst in cycle 8 of a 32-word burst.
  - Response: out_valid=0 and sram_cena=1 immediately (asynchronous); no stale beats after release; a new burst of addr=0, len=1 returns mem[0], mem[1].
